// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder
// Description : Handshaked WIDTH-bit adder that resolves one 4-bit CLA nibble
//               per clock. Optional ovf output: NIBBLE_SERIAL_ADDER_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int N   = WIDTH / 4;
   localparam int K_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [K_W-1:0] C_LAST = K_W'(N - 1);
   localparam logic [K_W-1:0] C_ONE  = K_W'(1);

   generate
      if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
         $error("nibble_serial_adder: WIDTH must be a non-zero multiple of 4");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [K_W-1:0]   r_k;
   logic             r_carry;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_out_valid;
   logic             r_in_ready;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   logic             r_ovf;
`endif

   logic [3:0] w_na;
   logic [3:0] w_nb;
   logic [3:0] w_g;
   logic [3:0] w_p;
   logic [3:0] w_ns;
   logic       w_c0;
   logic       w_c1;
   logic       w_c2;
   logic       w_c3;
   logic       w_c4;

   assign w_na = r_a[{r_k, 2'b00} +: 4];
   assign w_nb = r_b[{r_k, 2'b00} +: 4];
   assign w_g  = w_na & w_nb;
   assign w_p  = w_na ^ w_nb;
   assign w_c0 = r_carry;

   // Flattened look-ahead: every carry is a two-level function of g/p/c0.
   assign w_c1 = w_g[0] | (w_p[0] & w_c0);
   assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c0);
   assign w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & w_c0);
   assign w_c4 = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c0);
   assign w_ns = w_p ^ {w_c3, w_c2, w_c1, w_c0};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_k         <= '0;
         r_carry     <= 1'b0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
         r_ovf       <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a        <= a;
                  r_b        <= b;
                  r_carry    <= cin;
                  r_k        <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= RUN;
               end
            end
            RUN: begin
               r_sum[{r_k, 2'b00} +: 4] <= w_ns;
               r_carry                  <= w_c4;
               r_k                      <= r_k + C_ONE;
               if (r_k == C_LAST) begin
                  r_cout      <= w_c4;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                  r_ovf       <= w_c3 ^ w_c4;
`endif
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign sum       = r_sum;
   assign cout      = r_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   assign ovf       = r_ovf;
`endif

endmodule
`default_nettype wire

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter: WIDTH, 32, operand width in bits; SHALL be a multiple of 4 and at least 4; N = WIDTH/4.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: in_valid  input  1  upstream operands valid.
REQ-005 Port: in_ready  output  1  block accepts operands; high only in IDLE.
REQ-006 Port: a  input  WIDTH  operand A.
REQ-007 Port: b  input  WIDTH  operand B.
REQ-008 Port: cin  input  1  carry-in.
REQ-009 Port: out_valid  output  1  result valid; high only in DONE.
REQ-010 Port: out_ready  input  1  downstream accepts result.
REQ-011 Port: sum  output  WIDTH  registered sum.
REQ-012 Port: cout  output  1  registered carry-out.
REQ-013 Port: ovf  output  1  signed overflow; present only with the macro in REQ-031.

Function
REQ-014 FSM states IDLE, RUN, DONE; the accept handshake SHALL be in_valid&in_ready at a rising edge.
REQ-015 IDLE: on accept, latch a, b, cin; clear nibble counter k to 0; go to RUN.
REQ-016 RUN: each cycle, nibble k SHALL be added with 4-bit carry-look-ahead: g=a&b, p=a^b, c1..c4 from flattened g/p/carry terms, and sum=p^c.
REQ-017 RUN: the carry-in of nibble 0 SHALL be the latched cin; the carry-in of nibble k>0 SHALL be the registered c4 of nibble k-1.
REQ-018 RUN: nibble result SHALL be written to sum[4k+3:4k], c4 to the carry register, then k increments.
REQ-019 RUN: after nibble N-1 is written, go to DONE with cout = final c4.
REQ-020 Latency: out_valid SHALL rise exactly N clock edges after the accept edge (8 for WIDTH=32; 1 for WIDTH=4).
REQ-021 DONE: out_valid=1; sum, cout and ovf SHALL hold stable until out_valid&out_ready at an edge, then go to IDLE.
REQ-022 in_valid in RUN or DONE SHALL be ignored; no operand capture and no state change.
REQ-023 Changes on a, b or cin after the accept edge SHALL NOT affect the result.
REQ-024 After the output handshake, sum and cout SHALL hold their last values until the next accept.
REQ-025 Back-to-back throughput with in_valid=out_ready=1 continuously SHALL be one result per N+2 cycles.
REQ-026 sum bits are partially updated during RUN; they are defined only while out_valid=1.

Reset
REQ-027 rst=1 SHALL immediately force the state to IDLE, regardless of clk.
REQ-028 rst=1 SHALL immediately force sum=0, cout=0, ovf=0, out_valid=0 and in_ready=1, regardless of clk.
REQ-029 rst=1 SHALL immediately clear k, the carry register and the operand registers, regardless of clk.
REQ-030 Reset during RUN or DONE SHALL abort the operation with no result delivered; the first accept after rst deasserts SHALL start a fresh operation.

Configuration
REQ-031 Macro NIBBLE_SERIAL_ADDER_OVF_EN defined: port ovf exists; at entry to DONE, ovf SHALL be c3 XOR c4 of nibble N-1 (carry into MSB XOR carry-out), registered and held like cout.
REQ-032 Macro NIBBLE_SERIAL_ADDER_OVF_EN undefined: port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=32)
REQ-033 a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1; out_valid rises 8 edges after accept.
REQ-034 a=0x12345678, b=0x9ABCDEF0, cin=1 -> sum=0xACF13569, cout=0.
REQ-035 Hold out_ready=0 for 5 cycles in DONE and pulse in_valid -> out_valid stays 1, sum stable, in_ready=0, no new capture.
REQ-036 rst pulse during RUN at k=3 -> outputs immediately 0, in_ready=1; next operation 0x1+0x1 -> sum=0x00000002, cout=0.
REQ-037 With the macro: a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1; a=0xFFFFFFFF, b=0x00000001 -> ovf=0.
REQ-038 in_valid=out_ready=1 continuously with 3 operand sets -> 3 correct results, out_valid rising edges exactly 10 cycles apart.
